// File: rtl/rotor0_btof_diff_test.sv
// rotor0_btof_diff_test
//
// Registered verification and diagnostic slice for Enigma rotor 0 (rotor I wiring,
// EKMFLGDQVZNTOWYHXUSPAIBRCJ). The block takes one letter per cycle and
// registers three results:
//   r0_data_out         - forward (entry to reflector) substitution of data_in
//   r0_reverse_data_out - reverse (reflector to entry) substitution of data_in
//   total_out           - reverse substitution of the forward result; for a
//                         valid letter this always equals data_in
// It is pure datapath: no FSM and no handshake. A new letter is accepted
// every cycle, and each result appears exactly one cycle later.
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst_n               in   synchronous active-low reset
//   data_in[4:0]        in   letter 0..25; values 26..31 are invalid
//   position[4:0]       in   rotor offset 0..25; values 26..31 are reduced by 26
//   r0_data_out[4:0]    out  fwd(data_in), or 31 when data_in is invalid
//   r0_reverse_data_out out  rev(data_in), or 31 when data_in is invalid
//   total_out[4:0]      out  rev(fwd(data_in)), or 31 when data_in is invalid
//   diff_err            out  only with ROTOR0_CHECK_EN: high when the round trip
//                            does not return the registered input, or when that
//                            input was invalid
//
// Optional feature macro: ROTOR0_CHECK_EN (adds the data_in shadow register and diff_err).
module rotor0_btof_diff_test (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] data_in,
  input  logic [4:0] position,
  output logic [4:0] r0_data_out,
  output logic [4:0] r0_reverse_data_out,
  output logic [4:0] total_out
`ifdef ROTOR0_CHECK_EN
  ,
  output logic       diff_err
`endif
);

  // Rotor I forward wiring.
  function automatic logic [4:0] w_fwd(input logic [4:0] i);
    logic [4:0] r;
    case (i)
      5'd0:  r = 5'd4;   5'd1:  r = 5'd10;  5'd2:  r = 5'd12;  5'd3:  r = 5'd5;
      5'd4:  r = 5'd11;  5'd5:  r = 5'd6;   5'd6:  r = 5'd3;   5'd7:  r = 5'd16;
      5'd8:  r = 5'd21;  5'd9:  r = 5'd25;  5'd10: r = 5'd13;  5'd11: r = 5'd19;
      5'd12: r = 5'd14;  5'd13: r = 5'd22;  5'd14: r = 5'd24;  5'd15: r = 5'd7;
      5'd16: r = 5'd23;  5'd17: r = 5'd20;  5'd18: r = 5'd18;  5'd19: r = 5'd15;
      5'd20: r = 5'd0;   5'd21: r = 5'd8;   5'd22: r = 5'd1;   5'd23: r = 5'd17;
      5'd24: r = 5'd2;   5'd25: r = 5'd9;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Inverse wiring: w_inv(w_fwd(i)) == i.
  function automatic logic [4:0] w_inv(input logic [4:0] i);
    logic [4:0] r;
    case (i)
      5'd0:  r = 5'd20;  5'd1:  r = 5'd22;  5'd2:  r = 5'd24;  5'd3:  r = 5'd6;
      5'd4:  r = 5'd0;   5'd5:  r = 5'd3;   5'd6:  r = 5'd5;   5'd7:  r = 5'd15;
      5'd8:  r = 5'd21;  5'd9:  r = 5'd25;  5'd10: r = 5'd1;   5'd11: r = 5'd4;
      5'd12: r = 5'd2;   5'd13: r = 5'd10;  5'd14: r = 5'd12;  5'd15: r = 5'd19;
      5'd16: r = 5'd7;   5'd17: r = 5'd23;  5'd18: r = 5'd18;  5'd19: r = 5'd11;
      5'd20: r = 5'd17;  5'd21: r = 5'd8;   5'd22: r = 5'd13;  5'd23: r = 5'd16;
      5'd24: r = 5'd14;  5'd25: r = 5'd9;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // (a + b) mod 26 for a, b in 0..25, using a 6-bit intermediate.
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  // (a - b) mod 26 for a, b in 0..25; the +26 is added before subtracting
  // so the 6-bit intermediate never goes negative.
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    if (a < b) d = {1'b0, a} + 6'd26 - {1'b0, b};
    else       d = {1'b0, a} - {1'b0, b};
    return d[4:0];
  endfunction

  logic [4:0] pos_eff;
  logic [4:0] fwd_c;
  logic [4:0] rev_c;
  logic [4:0] tot_c;
  logic       invalid_c;

  always_comb begin
    pos_eff   = (position >= 5'd26) ? (position - 5'd26) : position;
    invalid_c = (data_in > 5'd25);
    fwd_c     = sub26(w_fwd(add26(data_in, pos_eff)), pos_eff);
    rev_c     = sub26(w_inv(add26(data_in, pos_eff)), pos_eff);
    // The round trip is chained combinationally inside the same cycle.
    tot_c     = sub26(w_inv(add26(fwd_c, pos_eff)), pos_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_data_out         <= 5'd0;
      r0_reverse_data_out <= 5'd0;
      total_out           <= 5'd0;
    end else if (invalid_c) begin
      r0_data_out         <= 5'd31;
      r0_reverse_data_out <= 5'd31;
      total_out           <= 5'd31;
    end else begin
      r0_data_out         <= fwd_c;
      r0_reverse_data_out <= rev_c;
      total_out           <= tot_c;
    end
  end

`ifdef ROTOR0_CHECK_EN
  // Shadow of the input, aligned with the registered results.
  logic [4:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= 5'd0;
    else        data_q <= data_in;
  end

  // Decoded from registered state only. An invalid input is flagged explicitly,
  // since data_in=31 would otherwise match the forced total_out of 31.
  assign diff_err = (total_out != data_q) || (data_q > 5'd25);
`endif

endmodule

// File: tb/tb_rotor0_btof_diff_test.sv
// Testbench for rotor0_btof_diff_test.
// Every step drives one input set, pushes the expected packed result
// {diff_err, total_out, r0_reverse_data_out, r0_data_out} onto exp_q, and
// then pops and compares it one cycle later.
module tb_rotor0_btof_diff_test;

`ifdef ROTOR0_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] data_in;
  logic [4:0] position;
  logic [4:0] r0_data_out;
  logic [4:0] r0_reverse_data_out;
  logic [4:0] total_out;
  logic       diff_obs;
`ifdef ROTOR0_CHECK_EN
  logic       diff_err;
`endif

  rotor0_btof_diff_test dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .data_in             (data_in),
    .position            (position),
    .r0_data_out         (r0_data_out),
    .r0_reverse_data_out (r0_reverse_data_out),
    .total_out           (total_out)
`ifdef ROTOR0_CHECK_EN
    ,
    .diff_err            (diff_err)
`endif
  );

`ifdef ROTOR0_CHECK_EN
  assign diff_obs = diff_err;
`else
  assign diff_obs = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // reference model
  int w_tab[26]   = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
  int inv_tab[26] = '{20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9};

  logic [15:0] exp_q[$];
  int checks;
  int passes;
  int fails;

  function automatic logic [15:0] pk(input int f, input int r, input int t, input bit e);
    logic [15:0] v;
    v = {e & CHK, t[4:0], r[4:0], f[4:0]};
    return v;
  endfunction

  function automatic logic [15:0] model(input logic rs, input int d, input int p);
    int pe, f, r, t;
    if (!rs) return pk(0, 0, 0, 1'b0);
    if (d > 25) return pk(31, 31, 31, 1'b1);
    pe = p % 26;
    f = (w_tab[(d + pe) % 26] - pe + 26) % 26;
    r = (inv_tab[(d + pe) % 26] - pe + 26) % 26;
    t = (inv_tab[(f + pe) % 26] - pe + 26) % 26;
    return pk(f, r, t, t != d);
  endfunction

  // driver: apply one input set, push its expected result, check after the edge
  task automatic step(input string tag, input logic rs, input int d, input int p,
                      input logic [15:0] exp);
    logic [15:0] obs;
    logic [15:0] e;
    rst_n    = rs;
    data_in  = d[4:0];
    position = p[4:0];
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    obs = {diff_obs, total_out, r0_reverse_data_out, r0_data_out};
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty (got %h, required an entry)", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passes++;
      else begin
        fails++;
        $error("FAIL %s: d=%0d p=%0d got fwd=%0d rev=%0d tot=%0d err=%0b required fwd=%0d rev=%0d tot=%0d err=%0b",
               tag, d, p, obs[4:0], obs[9:5], obs[14:10], obs[15],
               e[4:0], e[9:5], e[14:10], e[15]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    fails    = 0;
    rst_n    = 1'b0;
    data_in  = 5'd7;
    position = 5'd3;
    @(negedge clk);

    step("reset", 1'b0, 7, 3, pk(0, 0, 0, 1'b0));
    step("reset_hold", 1'b0, 12, 9, pk(0, 0, 0, 1'b0));

    // position 0, letters A..D back to back
    step("p0_a", 1'b1, 0, 0, pk(4, 20, 0, 1'b0));
    step("p0_b", 1'b1, 1, 0, pk(10, 22, 1, 1'b0));
    step("p0_c", 1'b1, 2, 0, pk(12, 24, 2, 1'b0));
    step("p0_d", 1'b1, 3, 0, pk(5, 6, 3, 1'b0));

    step("p1_a", 1'b1, 0, 1, pk(9, 21, 0, 1'b0));
    step("p25_wrap", 1'b1, 1, 25, pk(5, model(1'b1, 1, 25) >> 5, 1, 1'b0));
    step("p27_reduce", 1'b1, 0, 27, pk(9, 21, 0, 1'b0));
    step("z_p0", 1'b1, 25, 0, pk(9, 9, 25, 1'b0));

    // reset in the middle of a stream, then resume
    step("mid_reset", 1'b0, 5, 4, pk(0, 0, 0, 1'b0));
    step("after_reset", 1'b1, 2, 0, pk(12, 24, 2, 1'b0));

    step("invalid_27", 1'b1, 27, 0, pk(31, 31, 31, 1'b1));
    step("invalid_31", 1'b1, 31, 12, pk(31, 31, 31, 1'b1));
    step("valid_after_bad", 1'b1, 3, 0, pk(5, 6, 3, 1'b0));

    // full sweep of valid letters and offsets
    for (int p = 0; p < 26; p++) begin
      for (int d = 0; d < 26; d++) begin
        step("sweep", 1'b1, d, p, model(1'b1, d, p));
      end
    end

    // random tail including out-of-range values and occasional resets
    for (int i = 0; i < 60; i++) begin
      int d, p;
      logic rs;
      d  = $urandom_range(0, 31);
      p  = $urandom_range(0, 31);
      rs = ($urandom_range(0, 9) != 0);
      step("random", rs, d, p, model(rs, d, p));
    end

    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL drain: scoreboard left %0d entries, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
